// File: rtl/rule_seq_pkg.sv
// rtl/rule_seq_pkg.sv - shared types and constants for the rule-enable sequencer
// Run modes, FSM states, vector width and the LFSR feedback helper.
package rule_seq_pkg;

  localparam int EN_W = 5;

  // Fibonacci taps 16,14,13,11 expressed as a mask over lfsr[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_REPLAY = 2'd1,
    MODE_RANDOM = 2'd2,
    MODE_RR     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYSRST = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/rule_trace_fifo.sv
// rtl/rule_trace_fifo.sv - synchronous trace FIFO feeding replay mode
// Extra pointer bit distinguishes full from empty; flush clears both pointers.
module rule_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_data = mem[rd_ptr[AW-1:0]];
  assign do_push   = push && !full && !flush;
  assign do_pop    = pop && !empty && !flush;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/rule_enable_sequencer.sv
// rtl/rule_enable_sequencer.sv - rule-enable and core-reset stimulus generator
// Outputs are registered from next-state values, so each state's outputs appear in that state's cycle.
module rule_enable_sequencer
  import rule_seq_pkg::*;
#(
  parameter int          DEPTH = 16,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      io_mode,
  input  logic [15:0]     io_steps,
  input  logic            io_start,
  input  logic            io_abort,
  input  logic            io_load_valid,
  output logic            io_load_ready,
  input  logic [EN_W-1:0] io_load_bits,
  output logic            io_sys_reset,
  output logic [EN_W-1:0] io_en_a,
  output logic            io_busy,
  output logic            io_done,
  output logic [31:0]     io_step_count
);

  localparam logic [15:0] SEED_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

  state_e          state;
  state_e          state_nx;
  mode_e           run_mode;
  logic [15:0]     steps_left;
  logic [15:0]     lfsr;
  logic [EN_W-1:0] rr_count;
  logic [EN_W-1:0] fifo_head;
  logic [EN_W-1:0] vec_nx;
  logic [EN_W-1:0] en_a_nx;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  logic            start_ok;
  logic            more;
  logic            advance;
  logic            sys_reset_nx;
  logic            done_nx;
  logic            busy_nx;

  assign io_load_ready = (state == ST_IDLE) && !fifo_full;
  assign fifo_push     = io_load_valid && io_load_ready;
  assign start_ok      = (state == ST_IDLE) && io_start && !io_abort &&
                         (mode_e'(io_mode) != MODE_IDLE);
  // replay runs until the FIFO drains; other modes count down the latched steps
  assign more          = (run_mode == MODE_REPLAY) ? !fifo_empty : (steps_left != 16'd0);

  rule_trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EN_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (io_abort),
    .push      (fifo_push),
    .push_data (io_load_bits),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:           if (start_ok) state_nx = ST_SYSRST;
      ST_SYSRST, ST_RUN: state_nx = more ? ST_RUN : ST_DONE;
      ST_DONE:           state_nx = ST_IDLE;
      default:           state_nx = ST_IDLE;
    endcase
    if (io_abort) state_nx = ST_IDLE;
  end

  always_comb begin
    advance = ((state == ST_SYSRST) || (state == ST_RUN)) && (state_nx == ST_RUN);
    case (run_mode)
      MODE_RANDOM: vec_nx = lfsr[EN_W-1:0];
      MODE_RR:     vec_nx = rr_count;
      default:     vec_nx = fifo_head;
    endcase
    en_a_nx      = advance ? vec_nx : '0;
    fifo_pop     = advance && (run_mode == MODE_REPLAY);
    sys_reset_nx = (state_nx == ST_IDLE) || (state_nx == ST_SYSRST);
    done_nx      = (state_nx == ST_DONE);
    busy_nx      = (state_nx != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      run_mode      <= MODE_IDLE;
      steps_left    <= '0;
      lfsr          <= SEED_INIT;
      rr_count      <= '0;
      io_en_a       <= '0;
      io_sys_reset  <= 1'b1;
      io_busy       <= 1'b0;
      io_done       <= 1'b0;
      io_step_count <= '0;
    end else begin
      io_en_a      <= en_a_nx;
      io_sys_reset <= sys_reset_nx;
      io_busy      <= busy_nx;
      io_done      <= done_nx;
      if (start_ok) begin
        run_mode      <= mode_e'(io_mode);
        steps_left    <= io_steps;
        rr_count      <= '0;
        io_step_count <= '0;
      end
      // the LFSR only moves when a random vector is actually issued
      if (advance) begin
        if (io_step_count != 32'hFFFF_FFFF) io_step_count <= io_step_count + 32'd1;
        if (run_mode != MODE_REPLAY) steps_left <= steps_left - 16'd1;
        if (run_mode == MODE_RANDOM) lfsr <= lfsr_step(lfsr);
        if (run_mode == MODE_RR)     rr_count <= rr_count + EN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rule_enable_sequencer.sv
// tb/tb_rule_enable_sequencer.sv - scoreboard bench for rule_enable_sequencer
// Stimulus pushes expected vectors and done counts; a negedge monitor pops and compares.
module tb_rule_enable_sequencer;

  localparam int          DEPTH = 16;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  io_mode = 2'd0;
  logic [15:0] io_steps = 16'd0;
  logic        io_start = 1'b0;
  logic        io_abort = 1'b0;
  logic        io_load_valid = 1'b0;
  logic        io_load_ready;
  logic [4:0]  io_load_bits = 5'd0;
  logic        io_sys_reset;
  logic [4:0]  io_en_a;
  logic        io_busy;
  logic        io_done;
  logic [31:0] io_step_count;

  always #5 clock = ~clock;

  rule_enable_sequencer #(.DEPTH(DEPTH), .SEED(SEED)) dut (
    .clock         (clock),
    .reset         (reset),
    .io_mode       (io_mode),
    .io_steps      (io_steps),
    .io_start      (io_start),
    .io_abort      (io_abort),
    .io_load_valid (io_load_valid),
    .io_load_ready (io_load_ready),
    .io_load_bits  (io_load_bits),
    .io_sys_reset  (io_sys_reset),
    .io_en_a       (io_en_a),
    .io_busy       (io_busy),
    .io_done       (io_done),
    .io_step_count (io_step_count)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [4:0]  exp_vec[$];
  int          exp_done[$];
  logic [15:0] m_lfsr;
  logic [4:0]  m_fifo[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] m_adv(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // monitor: a RUN cycle is busy with the core out of reset and no done pulse
  always @(negedge clock) begin
    if (io_busy === 1'b1 && io_sys_reset === 1'b0 && io_done === 1'b0) begin
      if (exp_vec.size() == 0) chk("extra_vector", 32'(exp_vec.size()), 32'd1);
      else chk("en_a", 32'(io_en_a), 32'(exp_vec.pop_front()));
    end
    if (io_done === 1'b1) begin
      if (exp_done.size() == 0) chk("extra_done", 32'(exp_done.size()), 32'd1);
      else chk("done_step_count_mon", io_step_count, 32'(exp_done.pop_front()));
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sys_reset"}, 32'(io_sys_reset), 32'd1);
    chk({tag, "_en_a"}, 32'(io_en_a), 32'd0);
    chk({tag, "_busy"}, 32'(io_busy), 32'd0);
    chk({tag, "_done"}, 32'(io_done), 32'd0);
    chk({tag, "_step_count"}, io_step_count, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1; io_start = 1'b0; io_abort = 1'b0; io_load_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk_reset_outputs("reset");
    chk("reset_ready", 32'(io_load_ready), 32'd1);
    reset = 1'b0;
    m_lfsr = SEED;
    m_fifo.delete();
    exp_vec.delete();
    exp_done.delete();
  endtask

  task automatic load(input logic [4:0] v);
    chk("load_ready", 32'(io_load_ready), 32'(m_fifo.size() < DEPTH));
    io_load_valid = 1'b1;
    io_load_bits  = v;
    @(negedge clock);
    io_load_valid = 1'b0;
    if (m_fifo.size() < DEPTH) m_fifo.push_back(v);
  endtask

  // stop_at > 0 aborts (or resets) during the stop_at-th RUN cycle
  task automatic run(input int mode, input int steps, input int stop_at, input bit by_reset);
    int nv_full, nv, runs, cyc;
    bit stopped;
    logic [4:0] v;
    nv_full = (mode == 1) ? m_fifo.size() : steps;
    stopped = (stop_at > 0) && (stop_at <= nv_full);
    nv      = stopped ? stop_at : nv_full;
    for (int i = 0; i < nv; i++) begin
      if (mode == 1)      v = m_fifo[i];
      else if (mode == 2) begin v = m_lfsr[4:0]; m_lfsr = m_adv(m_lfsr); end
      else                v = 5'(i % 32);
      exp_vec.push_back(v);
    end
    if (mode == 1 || stopped) m_fifo.delete();
    if (!stopped) exp_done.push_back(nv);

    io_mode = 2'(mode); io_steps = 16'(steps); io_start = 1'b1;
    @(negedge clock);
    io_start = 1'b0;
    chk("sysrst_sys_reset", 32'(io_sys_reset), 32'd1);
    chk("sysrst_en_a", 32'(io_en_a), 32'd0);
    chk("sysrst_busy", 32'(io_busy), 32'd1);
    runs = 0;
    for (cyc = 2; cyc < nv + 20; cyc++) begin
      @(negedge clock);
      if (io_busy && !io_sys_reset && !io_done) runs++;
      if (stopped && runs == stop_at) begin
        if (by_reset) begin
          reset = 1'b1;
          @(negedge clock);
          chk_reset_outputs("midrun_reset");
          reset = 1'b0;
          m_lfsr = SEED;
        end else begin
          io_abort = 1'b1;
          @(negedge clock);
          io_abort = 1'b0;
          chk("abort_busy", 32'(io_busy), 32'd0);
          chk("abort_en_a", 32'(io_en_a), 32'd0);
          chk("abort_done", 32'(io_done), 32'd0);
          chk("abort_sys_reset", 32'(io_sys_reset), 32'd1);
          chk("abort_ready", 32'(io_load_ready), 32'd1);
          chk("abort_step_count", io_step_count, 32'(stop_at));
        end
        return;
      end
      if (io_done) begin
        chk("done_cycle", 32'(cyc), 32'(nv + 2));
        chk("done_step_count", io_step_count, 32'(nv));
        chk("done_sys_reset", 32'(io_sys_reset), 32'd0);
        @(negedge clock);
        chk("idle_sys_reset", 32'(io_sys_reset), 32'd1);
        chk("idle_done", 32'(io_done), 32'd0);
        chk("idle_busy", 32'(io_busy), 32'd0);
        return;
      end
    end
    chk("run_timeout", 32'(cyc), 32'(nv + 2));
  endtask

  logic [4:0] t1_trace [10] = '{5'b00011, 5'b00101, 5'b10010, 5'b01111, 5'b00010,
                                5'b00110, 5'b10001, 5'b01110, 5'b00000, 5'b00000};

  initial begin
    do_reset();

    foreach (t1_trace[i]) load(t1_trace[i]);
    run(1, 0, 0, 0);

    foreach (t1_trace[i]) load(t1_trace[i]);
    run(1, 0, 3, 0);

    for (int i = 0; i < 17; i++) load(5'($urandom));
    run(1, 0, 0, 0);

    do_reset();
    run(2, 4, 0, 0);
    run(3, 34, 0, 0);

    for (int i = 0; i < 4; i++) load(5'($urandom));
    run(2, 20, 5, 1);

    load(5'h1f);
    io_mode = 2'd2; io_steps = 16'd5; io_start = 1'b1; io_abort = 1'b1;
    @(negedge clock);
    io_start = 1'b0; io_abort = 1'b0;
    m_fifo.delete();
    chk("start_abort_busy", 32'(io_busy), 32'd0);
    chk("start_abort_sys_reset", 32'(io_sys_reset), 32'd1);
    chk("start_abort_ready", 32'(io_load_ready), 32'd1);

    io_mode = 2'd0; io_start = 1'b1;
    @(negedge clock);
    io_start = 1'b0;
    chk("mode0_start_busy", 32'(io_busy), 32'd0);

    run(1, 0, 0, 0);

    for (int r = 0; r < 10; r++) begin
      int n, mode, steps, stop;
      n     = $urandom_range(0, 18);
      mode  = $urandom_range(1, 3);
      steps = $urandom_range(0, 40);
      stop  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0;
      for (int i = 0; i < n; i++) load(5'($urandom));
      run(mode, steps, stop, 0);
    end

    repeat (3) @(negedge clock);
    chk("vec_queue_drained", 32'(exp_vec.size()), 32'd0);
    chk("done_queue_drained", 32'(exp_done.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
